// File: rtl/weighted_rr_arbiter_param.sv
// Weighted round-robin arbiter draining NUM_CH first-word-fall-through channel FIFOs.
// Each grant serves up to its latched weight in words before rotating to the next channel.
module wrr_lane #(
  parameter int WGT_W = 3
) (
  input  logic             i_empty,
  input  logic [WGT_W-1:0] i_weight,
  output logic             o_elig
);
  assign o_elig = !i_empty && (|i_weight);
endmodule

module weighted_rr_arbiter_param #(
  parameter  int NUM_CH = 4,
  parameter  int DATA_W = 4,
  parameter  int WGT_W  = 3,
  localparam int ARB_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enb,
  input  logic [NUM_CH*DATA_W-1:0] vc_data,
  input  logic [NUM_CH-1:0]        vc_empty,
  input  logic [NUM_CH*WGT_W-1:0]  vc_weight,
  input  logic                     out_ready,
  output logic [NUM_CH-1:0]        vc_pop,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  output logic [ARB_W-1:0]         out_chan,
  output logic [ARB_W-1:0]         arbiter,
  output logic                     quantum_done
);
  typedef enum logic {S_IDLE, S_SERVE} state_t;

  state_t            r_state;
  logic [ARB_W-1:0]  r_arb, r_base, r_chan;
  logic [WGT_W-1:0]  r_cnt, r_quant;
  logic [DATA_W-1:0] r_data;
  logic              r_valid, r_done;

  logic [NUM_CH-1:0][DATA_W-1:0] w_data;
  logic [NUM_CH-1:0][WGT_W-1:0]  w_wgt;
  logic [NUM_CH-1:0]             w_elig, w_rot;
  logic [ARB_W-1:0]              w_off, w_next, w_next_base;
  logic [ARB_W:0]                w_sum;
  logic [WGT_W-1:0]              w_cnt_inc;
  logic                          w_found, w_serve, w_head_empty, w_pop, w_end, w_grant;

  assign w_data = vc_data;
  assign w_wgt  = vc_weight;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    wrr_lane #(.WGT_W(WGT_W)) u_lane (
      .i_empty (vc_empty[g]),
      .i_weight(w_wgt[g]),
      .o_elig  (w_elig[g])
    );
  end

  // Rotate so bit 0 is the search origin, pick lowest set bit, then rotate back.
  assign w_rot = NUM_CH'({w_elig, w_elig} >> r_base);
  always_comb begin
    w_off = '0;
    for (int k = NUM_CH-1; k >= 0; k--)
      if (w_rot[k]) w_off = ARB_W'(k);
  end
  assign w_found     = |w_elig;
  assign w_sum       = {1'b0, r_base} + {1'b0, w_off};
  assign w_next      = (w_sum >= (ARB_W+1)'(NUM_CH)) ? ARB_W'(w_sum - (ARB_W+1)'(NUM_CH))
                                                     : ARB_W'(w_sum);
  assign w_next_base = (w_next == ARB_W'(NUM_CH-1)) ? '0 : w_next + ARB_W'(1);

  assign w_serve      = (r_state == S_SERVE);
  assign w_head_empty = vc_empty[r_arb];
  assign w_pop        = !rst && enb && w_serve && out_ready && !w_head_empty;
  assign w_cnt_inc    = r_cnt + WGT_W'(1);
  // An empty head ends the quantum even while downstream stalls.
  assign w_end        = w_serve && enb && (w_head_empty || (w_pop && w_cnt_inc == r_quant));
  assign w_grant      = enb && w_found && (!w_serve || w_end);

  assign vc_pop = w_pop ? (NUM_CH'(1) << r_arb) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_arb   <= '0;
      r_base  <= '0;
      r_cnt   <= '0;
      r_quant <= '0;
      r_data  <= '0;
      r_chan  <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_valid <= w_pop;
      r_done  <= w_end;
      if (w_pop) begin
        r_data <= w_data[r_arb];
        r_chan <= r_arb;
        r_cnt  <= w_cnt_inc;
      end
      if (w_grant) begin
        r_state <= S_SERVE;
        r_arb   <= w_next;
        r_base  <= w_next_base;
        r_quant <= w_wgt[w_next];
        r_cnt   <= '0;
      end else if (w_end) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end
    end
  end

  assign out_data     = r_data;
  assign out_valid    = r_valid;
  assign out_chan     = r_chan;
  assign arbiter      = r_arb;
  assign quantum_done = r_done;
endmodule

// File: tb/tb_weighted_rr_arbiter_param.sv
// Directed vector bench for weighted_rr_arbiter_param (NUM_CH=4, DATA_W=4, WGT_W=3).
module tb_weighted_rr_arbiter_param;
  logic        clk = 1'b0;
  logic        rst, enb, out_ready;
  logic [15:0] vc_data;
  logic [3:0]  vc_empty, vc_pop;
  logic [11:0] vc_weight;
  logic [3:0]  out_data;
  logic        out_valid, quantum_done;
  logic [1:0]  out_chan, arbiter;

  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] h_chan;
  logic [3:0] h_data;

  typedef struct {
    logic rst, enb, rdy;
    logic [3:0]  empty;
    logic [11:0] wgt;
    logic [3:0]  pop;
    logic valid;
    logic [1:0] chan, arb;
    logic done;
  } vec_t;

  vec_t tbl[$];

  weighted_rr_arbiter_param dut (
    .clk(clk), .rst(rst), .enb(enb), .vc_data(vc_data), .vc_empty(vc_empty),
    .vc_weight(vc_weight), .out_ready(out_ready), .vc_pop(vc_pop), .out_data(out_data),
    .out_valid(out_valid), .out_chan(out_chan), .arbiter(arbiter), .quantum_done(quantum_done)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] wg(int a0, int a1, int a2, int a3);
    return {3'(a3), 3'(a2), 3'(a1), 3'(a0)};
  endfunction

  function automatic vec_t mk(logic r, logic e, logic y, logic [3:0] em, logic [11:0] w,
                              logic [3:0] p, logic v, logic [1:0] c, logic [1:0] a, logic d);
    vec_t t;
    t.rst = r; t.enb = e; t.rdy = y; t.empty = em; t.wgt = w;
    t.pop = p; t.valid = v; t.chan = c; t.arb = a; t.done = d;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    rst = v.rst; enb = v.enb; out_ready = v.rdy; vc_empty = v.empty; vc_weight = v.wgt;
    #1;
    check({tag, " vc_pop"}, 32'(vc_pop), 32'(v.pop));
    @(posedge clk);
    #1;
    if (v.rst) begin
      h_chan = 2'd0; h_data = 4'd0;
    end else if (v.valid) begin
      h_chan = v.chan; h_data = 4'hA + 4'(v.chan);
    end
    check({tag, " out_valid"},    32'(out_valid),    32'(v.valid));
    check({tag, " out_chan"},     32'(out_chan),     32'(h_chan));
    check({tag, " out_data"},     32'(out_data),     32'(h_data));
    check({tag, " arbiter"},      32'(arbiter),      32'(v.arb));
    check({tag, " quantum_done"}, 32'(quantum_done), 32'(v.done));
  endtask

  initial begin
    logic [11:0] w;
    rst = 1'b1; enb = 1'b1; out_ready = 1'b1; vc_empty = 4'hF; vc_weight = '0;
    vc_data = {4'hD, 4'hC, 4'hB, 4'hA};
    h_chan = 2'd0; h_data = 4'd0;

    // weights {2,1,1,1}: 0,0,1,2,3,0,0,1
    w = wg(2, 1, 1, 1);
    tbl.push_back(mk(1, 1, 1, 4'h0, w, 4'h0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 4'h0, w, 4'h0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 4'h0, w, 4'h1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 4'h0, w, 4'h1, 1, 0, 1, 1));
    tbl.push_back(mk(0, 1, 1, 4'h0, w, 4'h2, 1, 1, 2, 1));
    tbl.push_back(mk(0, 1, 1, 4'h0, w, 4'h4, 1, 2, 3, 1));
    tbl.push_back(mk(0, 1, 1, 4'h0, w, 4'h8, 1, 3, 0, 1));
    tbl.push_back(mk(0, 1, 1, 4'h0, w, 4'h1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 4'h0, w, 4'h1, 1, 0, 1, 1));
    tbl.push_back(mk(0, 1, 1, 4'h0, w, 4'h2, 1, 1, 2, 1));
    // stall mid-quantum (ready low x3, then enb low), quantum resumes
    w = wg(3, 1, 1, 1);
    tbl.push_back(mk(1, 1, 1, 4'h0, w, 4'h0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 4'h0, w, 4'h0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 4'h0, w, 4'h1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'h0, w, 4'h0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'h0, w, 4'h0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'h0, w, 4'h0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 4'h0, w, 4'h0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 4'h0, w, 4'h1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 4'h0, w, 4'h1, 1, 0, 1, 1));
    tbl.push_back(mk(0, 1, 1, 4'h0, w, 4'h2, 1, 1, 2, 1));
    // weight 0 on channel 2: 0,1,3,0,1
    w = wg(1, 1, 0, 1);
    tbl.push_back(mk(1, 1, 1, 4'h0, w, 4'h0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 4'h0, w, 4'h0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 4'h0, w, 4'h1, 1, 0, 1, 1));
    tbl.push_back(mk(0, 1, 1, 4'h0, w, 4'h2, 1, 1, 3, 1));
    tbl.push_back(mk(0, 1, 1, 4'h0, w, 4'h8, 1, 3, 0, 1));
    tbl.push_back(mk(0, 1, 1, 4'h0, w, 4'h1, 1, 0, 1, 1));
    tbl.push_back(mk(0, 1, 1, 4'h0, w, 4'h2, 1, 1, 3, 1));
    // channel 1 (weight 3) holds one word, empties, grant moves to 2
    w = wg(1, 3, 1, 1);
    tbl.push_back(mk(1, 1, 1, 4'h0, w, 4'h0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 4'h0, w, 4'h0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 4'h0, w, 4'h1, 1, 0, 1, 1));
    tbl.push_back(mk(0, 1, 1, 4'h0, w, 4'h2, 1, 1, 1, 0));
    tbl.push_back(mk(0, 1, 1, 4'h2, w, 4'h0, 0, 0, 2, 1));
    tbl.push_back(mk(0, 1, 1, 4'h2, w, 4'h4, 1, 2, 3, 1));
    // reset mid-quantum on channel 2
    w = wg(1, 1, 3, 1);
    tbl.push_back(mk(1, 1, 1, 4'h0, w, 4'h0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 4'h0, w, 4'h0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 4'h0, w, 4'h1, 1, 0, 1, 1));
    tbl.push_back(mk(0, 1, 1, 4'h0, w, 4'h2, 1, 1, 2, 1));
    tbl.push_back(mk(0, 1, 1, 4'h0, w, 4'h4, 1, 2, 2, 0));
    tbl.push_back(mk(1, 1, 1, 4'h0, w, 4'h0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 4'h0, w, 4'h0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 4'h0, w, 4'h1, 1, 0, 1, 1));
    // all empty -> IDLE; channel 3 arrives, sole eligible channel is re-granted
    w = wg(1, 1, 1, 1);
    tbl.push_back(mk(1, 1, 1, 4'h0, w, 4'h0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 4'h0, w, 4'h0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 4'h0, w, 4'h1, 1, 0, 1, 1));
    tbl.push_back(mk(0, 1, 1, 4'hF, w, 4'h0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, 1, 4'hF, w, 4'h0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1, 4'h7, w, 4'h0, 0, 0, 3, 0));
    tbl.push_back(mk(0, 1, 1, 4'h7, w, 4'h8, 1, 3, 3, 1));

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // weight change mid-quantum only applies at the next grant
    apply(mk(1, 1, 1, 4'h0, wg(2, 1, 1, 1), 4'h0, 0, 0, 0, 0), "wchg0");
    apply(mk(0, 1, 1, 4'h0, wg(2, 1, 1, 1), 4'h0, 0, 0, 0, 0), "wchg1");
    apply(mk(0, 1, 1, 4'h0, wg(2, 1, 1, 1), 4'h1, 1, 0, 0, 0), "wchg2");
    apply(mk(0, 1, 1, 4'h0, wg(1, 1, 1, 1), 4'h1, 1, 0, 1, 1), "wchg3");
    apply(mk(0, 1, 1, 4'h0, wg(1, 1, 1, 1), 4'h2, 1, 1, 2, 1), "wchg4");
    apply(mk(0, 1, 1, 4'h0, wg(1, 1, 1, 1), 4'h4, 1, 2, 3, 1), "wchg5");
    apply(mk(0, 1, 1, 4'h0, wg(1, 1, 1, 1), 4'h8, 1, 3, 0, 1), "wchg6");
    apply(mk(0, 1, 1, 4'h0, wg(1, 1, 1, 1), 4'h1, 1, 0, 1, 1), "wchg7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
